sa_feeder: RTL and testbench

Operand feeder for the `N`×`N` output-stationary systolic array. Accepts one reduction slice (column `k` of A, row `k` of B) per handshake beat and buffers a full `K`-deep tile. It then clears the array and drives its `a_in`/`b_in`/`en` inputs with the diagonal skew the array requires. After the array has finished accumulating, it pulses `done`; at that point `acc_out` holds C = A·B.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_tile_buf.sv | 53 +++++
 rtl/sa_feeder.sv | 131 +++++++++++++
 tb/tb_sa_feeder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: types and defaults shared by the systolic-array operand feeder and the array itself.
//   sa_feed_state_t : feeder FSM state (load tile, clear array, feed skewed operands, done pulse)
//   DefaultWidth    : default signed operand width
//   DefaultN        : default array dimension
//   feed_cycles()   : length of the FEED phase for a given K, N and PE latency
package sa_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultN     = 2;

    typedef enum logic [1:0] {
        StLoad,
        StClear,
        StFeed,
        StDone
    } sa_feed_state_t;

    // The last operand reaches PE(N-1,N-1) at t = K-1 + 2(N-1); PE_LAT more cycles settle acc_out.
    function automatic int unsigned feed_cycles(input int unsigned k, input int unsigned n,
                                                input int unsigned pe_lat);
        return k + 2 * n - 2 + pe_lat;
    endfunction

endpackage

// File: rtl/sa_tile_buf.sv
// sa_tile_buf: K-deep operand buffer for one tile, with a diagonally skewed read.
//   clk          : clock, rising edge
//   wr_en        : write beat wr_idx
//   wr_idx       : beat index 0..K-1
//   wr_a, wr_b   : column k of A, row k of B
//   t            : feed cycle index
//   rd_a[i]      : A[i][t-i] when 0 <= t-i < K, else 0
//   rd_b[j]      : B[t-j][j] when 0 <= t-j < K, else 0
module sa_tile_buf
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned N     = DefaultN,
    parameter int unsigned K     = 4,
    parameter int unsigned TW    = 4,
    parameter int unsigned BW    = 3
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [BW-1:0]             wr_idx,
    input  logic [N-1:0][WIDTH-1:0]   wr_a,
    input  logic [N-1:0][WIDTH-1:0]   wr_b,
    input  logic [TW-1:0]             t,
    output logic [N-1:0][WIDTH-1:0]   rd_a,
    output logic [N-1:0][WIDTH-1:0]   rd_b
);

    localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;

    logic [N-1:0][WIDTH-1:0] a_mem [K];
    logic [N-1:0][WIDTH-1:0] b_mem [K];

    // No reset: every entry is rewritten before the tile that uses it is fed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            a_mem[AW'(wr_idx)] <= wr_a;
            b_mem[AW'(wr_idx)] <= wr_b;
        end
    end

    // Row i / column j lags by i / j cycles; test t >= i before subtracting.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            rd_a[i] = '0;
            rd_b[i] = '0;
            if (int'(t) >= i && (int'(t) - i) < int'(K)) begin
                rd_a[i] = a_mem[AW'(int'(t) - i)][i];
                rd_b[i] = b_mem[AW'(int'(t) - i)][i];
            end
        end
    end

endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: operand feeder for an N x N output-stationary systolic array.
// Buffers K beats (column k of A, row k of B), clears the array, then feeds the skewed
// operands for F = K+2N-2+PE_LAT cycles and pulses done once acc_out is final.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : load beat valid
//   in_ready     : feeder accepts a beat (LOAD state)
//   in_a, in_b   : in_a[i] = A[i][k], in_b[j] = B[k][j]
//   sa_rst_n     : array clear, active-low (CLEAR state or rst)
//   sa_en        : array enable (FEED state)
//   sa_a, sa_b   : array a_in / b_in, zero outside FEED
//   busy         : not in LOAD
//   done         : one-cycle pulse, acc_out holds C = A*B
module sa_feeder
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned N      = DefaultN,
    parameter int unsigned K      = 4,
    parameter int unsigned PE_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0][WIDTH-1:0]   in_a,
    input  logic [N-1:0][WIDTH-1:0]   in_b,
    output logic                      sa_rst_n,
    output logic                      sa_en,
    output logic [N-1:0][WIDTH-1:0]   sa_a,
    output logic [N-1:0][WIDTH-1:0]   sa_b,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned F  = feed_cycles(K, N, PE_LAT);
    localparam int unsigned TW = $clog2(F + 1);
    localparam int unsigned BW = $clog2(K + 1);

    localparam logic [TW-1:0] TLast    = TW'(F - 1);
    localparam logic [BW-1:0] BeatLast = BW'(K - 1);

    sa_feed_state_t          state_q;
    logic [BW-1:0]           beat_q;
    logic [TW-1:0]           t_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    sa_en_q;
    logic                    wr_en;
    logic [N-1:0][WIDTH-1:0] rd_a;
    logic [N-1:0][WIDTH-1:0] rd_b;

    assign wr_en = in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            beat_q     <= '0;
            t_q        <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sa_en_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (wr_en) begin
                        if (beat_q == BeatLast) begin
                            beat_q     <= '0;
                            state_q    <= StClear;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StClear: begin
                    state_q <= StFeed;
                    t_q     <= '0;
                    sa_en_q <= 1'b1;
                end
                StFeed: begin
                    if (t_q == TLast) begin
                        state_q <= StDone;
                        sa_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q    <= StLoad;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    sa_tile_buf #(
        .WIDTH (WIDTH),
        .N     (N),
        .K     (K),
        .TW    (TW),
        .BW    (BW)
    ) u_tile_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (beat_q),
        .wr_a   (in_a),
        .wr_b   (in_b),
        .t      (t_q),
        .rd_a   (rd_a),
        .rd_b   (rd_b)
    );

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sa_en    = sa_en_q;
    // Clear follows rst directly so the array resets in the same cycle as the feeder.
    assign sa_rst_n = !(rst || state_q == StClear);
    assign sa_a     = (state_q == StFeed) ? rd_a : '0;
    assign sa_b     = (state_q == StFeed) ? rd_b : '0;

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: two instances (K=2 and K=4, N=2), each driving a behavioural
// output-stationary array. Expected C is pushed to a scoreboard when a tile is driven and
// compared against the array accumulators when done pulses.
module tb_sa_feeder;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int K0 = 2;
    localparam int K1 = 4;
    localparam int PL = 1;
    localparam int F0 = K0 + 2 * N - 2 + PL;
    localparam int F1 = K1 + 2 * N - 2 + PL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst      [2];
    logic                in_valid [2];
    logic                in_ready [2];
    logic                sa_rst_n [2];
    logic                sa_en    [2];
    logic                busy     [2];
    logic                done     [2];
    logic [N-1:0][W-1:0] sa_a     [2];
    logic [N-1:0][W-1:0] sa_b     [2];
    logic [N-1:0][W-1:0] in_a;
    logic [N-1:0][W-1:0] in_b;

    sa_feeder #(.WIDTH(W), .N(N), .K(K0), .PE_LAT(PL)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b), .sa_rst_n(sa_rst_n[0]), .sa_en(sa_en[0]),
        .sa_a(sa_a[0]), .sa_b(sa_b[0]), .busy(busy[0]), .done(done[0])
    );

    sa_feeder #(.WIDTH(W), .N(N), .K(K1), .PE_LAT(PL)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b), .sa_rst_n(sa_rst_n[1]), .sa_en(sa_en[1]),
        .sa_a(sa_a[1]), .sa_b(sa_b[1]), .busy(busy[1]), .done(done[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural array: a moves right, b moves down, each PE accumulates a*b when enabled.
    int acc [2][N][N];
    int ar  [2][N][N];
    int br  [2][N][N];
    int pa  [2][N][N];
    int pb  [2][N][N];

    always_comb begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[s][i][j] = (j == 0) ? int'($signed(sa_a[s][i])) : ar[s][i][(j > 0) ? j - 1 : 0];
                    pb[s][i][j] = (i == 0) ? int'($signed(sa_b[s][j])) : br[s][(i > 0) ? i - 1 : 0][j];
                end
    end

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (!sa_rst_n[s]) begin
                        acc[s][i][j] <= 0;
                        ar[s][i][j]  <= 0;
                        br[s][i][j]  <= 0;
                    end else if (sa_en[s]) begin
                        acc[s][i][j] <= acc[s][i][j] + pa[s][i][j] * pb[s][i][j];
                        ar[s][i][j]  <= pa[s][i][j];
                        br[s][i][j]  <= pb[s][i][j];
                    end
                end
    end

    // Scoreboard and the operands of the tile currently in flight per instance.
    int exp_q0[$];
    int exp_q1[$];
    int cur_a [2][N][K1];
    int cur_b [2][K1][N];
    int ft [2];
    bit done_prev [2];

    function automatic int kof(input int s);
        return (s == 0) ? K0 : K1;
    endfunction

    function automatic int fof(input int s);
        return (s == 0) ? F0 : F1;
    endfunction

    function automatic int exp_a(input int s, input int i, input int t);
        if (t >= i && t - i < kof(s)) return cur_a[s][i][t-i];
        return 0;
    endfunction

    function automatic int exp_b(input int s, input int j, input int t);
        if (t >= j && t - j < kof(s)) return cur_b[s][t-j][j];
        return 0;
    endfunction

    // Monitor: skewed operands during FEED, zeros elsewhere, C at done.
    initial begin
        int e;
        ft[0] = 0; ft[1] = 0; done_prev[0] = 0; done_prev[1] = 0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (rst[s]) begin
                    ft[s] = 0;
                    done_prev[s] = 0;
                end else begin
                    if (sa_en[s]) begin
                        if (ft[s] == 0)
                            for (int i = 0; i < N; i++)
                                for (int j = 0; j < N; j++) check("acc_clr", acc[s][i][j], 0);
                        for (int i = 0; i < N; i++) begin
                            check("sa_a", $signed(sa_a[s][i]), exp_a(s, i, ft[s]));
                            check("sa_b", $signed(sa_b[s][i]), exp_b(s, i, ft[s]));
                        end
                        ft[s]++;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            check("idle_a", sa_a[s][i], 0);
                            check("idle_b", sa_b[s][i], 0);
                        end
                    end
                    if (done[s]) begin
                        check("feed_len", ft[s], fof(s));
                        check("done_1cyc", done_prev[s], 0);
                        check("sb_size", (s == 0) ? exp_q0.size() : exp_q1.size(), N * N);
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++) begin
                                e = 0;
                                if (s == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
                                if (s == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                                check("acc", acc[s][i][j], e);
                            end
                        ft[s] = 0;
                    end
                    done_prev[s] = done[s];
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the last accepted beat (+gap).
    task automatic send_tile(input int s, input int a[N][K1], input int b[K1][N], input int gap);
        int k;
        int c;
        k = kof(s);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c = 0;
                for (int kk = 0; kk < k; kk++) c += a[i][kk] * b[kk][j];
                if (s == 0) exp_q0.push_back(c);
                else exp_q1.push_back(c);
            end
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < K1; kk++) begin
                cur_a[s][i][kk] = a[i][kk];
                cur_b[s][kk][i] = b[kk][i];
            end
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                in_a[i] = W'(a[i][kk]);
                in_b[i] = W'(b[kk][i]);
            end
            in_valid[s] = 1'b1;
            for (int g = 0; g < 100 && !in_ready[s]; g++) @(negedge clk);
            if (!in_ready[s]) begin
                check("ready_to", in_ready[s], 1);
                in_valid[s] = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid[s] = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Waits for done; optionally pulses in_valid every third cycle while the feeder is busy.
    task automatic wait_done(input int s, output int dc, input bit pulse);
        for (int g = 0; g < 200; g++) begin
            if (done[s]) begin
                in_valid[s] = 1'b0;
                dc = cyc;
                return;
            end
            if (pulse && (g % 3 == 0)) begin
                in_valid[s] = 1'b1;
                in_a = {N{8'sd77}};
                in_b = {N{8'sd77}};
                check("ign_rdy", in_ready[s], 0);
            end else begin
                in_valid[s] = 1'b0;
            end
            @(negedge clk);
        end
        in_valid[s] = 1'b0;
        check("done_to", done[s], 1);
        dc = cyc;
    endtask

    initial begin
        int ta [N][K1];
        int tb [K1][N];
        int ia [N][K1];
        int nb [K1][N];
        int ra [N][K1];
        int rb [K1][N];
        int d1, d2, seen;

        ta = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}};
        tb = '{'{5, 6}, '{7, 8}, '{0, 0}, '{0, 0}};
        ia = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}};
        nb = '{'{9, -9}, '{-9, 9}, '{0, 0}, '{0, 0}};
        ra = '{'{5, -3, 0, 0}, '{7, 2, 0, 0}};
        rb = '{'{-4, 6}, '{11, -1}, '{0, 0}, '{0, 0}};

        rst[0] = 1'b1; rst[1] = 1'b1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", in_ready[s], 1);
            check("rst_sa_rst_n", sa_rst_n[s], 0);
            check("rst_sa_en", sa_en[s], 0);
            check("rst_busy", busy[s], 0);
            check("rst_done", done[s], 0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("post_rst_n", sa_rst_n[s], 1);
            check("post_ready", in_ready[s], 1);
        end

        // Basic tile, then back-to-back A=I tile presented the cycle after done.
        send_tile(0, ta, tb, 0);
        wait_done(0, d1, 1'b0);
        @(negedge clk);
        send_tile(0, ia, nb, 0);
        wait_done(0, d2, 1'b0);
        check("b2b_lat", d2 - d1, K0 + F0 + 2);

        // Gapped input with ignored pulses while busy, then an unaffected follow-up tile.
        @(negedge clk);
        send_tile(0, ta, tb, 2);
        wait_done(0, d1, 1'b1);
        @(negedge clk);
        send_tile(0, ia, nb, 0);
        wait_done(0, d1, 1'b0);

        // Reset at FEED t=1, then a fresh tile.
        @(negedge clk);
        send_tile(0, ra, rb, 0);
        seen = 0;
        for (int g = 0; g < 50 && seen < 2; g++) begin
            @(negedge clk);
            if (sa_en[0]) seen++;
        end
        check("rst_at_t1", seen, 2);
        rst[0] = 1'b1;
        exp_q0.delete();
        @(negedge clk);
        check("mid_rst_ready", in_ready[0], 1);
        check("mid_rst_en", sa_en[0], 0);
        check("mid_rst_n", sa_rst_n[0], 0);
        check("mid_rst_busy", busy[0], 0);
        rst[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_rel", sa_rst_n[0], 1);
        send_tile(0, ta, tb, 0);
        wait_done(0, d1, 1'b0);

        // Signed extremes on the K=4 instance.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K1; k++) begin
                ra[i][k] = -128;
                rb[k][i] = -128;
            end
        @(negedge clk);
        send_tile(1, ra, rb, 0);
        wait_done(1, d1, 1'b0);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K1; k++) rb[k][i] = 127;
        @(negedge clk);
        send_tile(1, ra, rb, 0);
        wait_done(1, d1, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
